// File: rtl/sha256_sigma_pkg.sv
// Shared encodings for the sequenced SHA-256 sigma unit.
// The operation table maps (function, step) to a rotate/shift amount.
package sha256_sigma_pkg;

  localparam int SIG_WORD_W = 32;
  localparam int SIG_AMT_W  = 5;

  typedef enum logic [1:0] {
    F_BSIG0 = 2'd0,
    F_BSIG1 = 2'd1,
    F_SSIG0 = 2'd2,
    F_SSIG1 = 2'd3
  } func_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP0  = 3'd1,
    OP1  = 3'd2,
    OP2  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Returns {shr, amt}; only sigma0/sigma1 use a logical shift, and only on step 2.
  function automatic logic [SIG_AMT_W:0] op_sel(input func_t f, input logic [1:0] step);
    logic [SIG_AMT_W:0] r;
    r = '0;
    case ({f, step})
      {F_BSIG0, 2'd0}: r = {1'b0, 5'd2};
      {F_BSIG0, 2'd1}: r = {1'b0, 5'd13};
      {F_BSIG0, 2'd2}: r = {1'b0, 5'd22};
      {F_BSIG1, 2'd0}: r = {1'b0, 5'd6};
      {F_BSIG1, 2'd1}: r = {1'b0, 5'd11};
      {F_BSIG1, 2'd2}: r = {1'b0, 5'd25};
      {F_SSIG0, 2'd0}: r = {1'b0, 5'd7};
      {F_SSIG0, 2'd1}: r = {1'b0, 5'd18};
      {F_SSIG0, 2'd2}: r = {1'b1, 5'd3};
      {F_SSIG1, 2'd0}: r = {1'b0, 5'd17};
      {F_SSIG1, 2'd1}: r = {1'b0, 5'd19};
      {F_SSIG1, 2'd2}: r = {1'b1, 5'd10};
      default:         r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rotr_var.sv
// Variable-amount rotate right, or logical shift right when shr is set.
// Purely combinational; amt=0 passes x through unchanged.
module rotr_var #(
  parameter int WORD_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic [WORD_W-1:0] x,
  input  logic [AMT_W-1:0]  amt,
  input  logic              shr,
  output logic [WORD_W-1:0] y
);

  // A left shift by the full word width yields zero, which makes amt=0 a clean pass-through.
  logic [AMT_W:0] lamt;

  assign lamt = (AMT_W+1)'(WORD_W) - {1'b0, amt};
  assign y    = shr ? (x >> amt) : ((x >> amt) | (x << lamt));

endmodule

// File: rtl/sha256_sigma_seq.sv
// Computes one SHA-256 sigma function via a single shared rotator, one term per clock.
// Result valid 3 edges after accept; held in DONE until resp_ready, no requests taken meanwhile.
module sha256_sigma_seq
  import sha256_sigma_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_func,
  input  logic [WORD_W-1:0] req_word,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_word,
  output logic              busy
);

  if (WORD_W != 32 || AMT_W != 5) begin : g_bad_width
    $error("sha256_sigma_seq supports only WORD_W=32, AMT_W=5");
  end

  state_t            state;
  func_t             func;
  logic [1:0]        step;
  logic [WORD_W-1:0] opnd;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] unit_out;
  logic [AMT_W-1:0]  amt;
  logic              shr;

  assign {shr, amt} = op_sel(func, step);
  assign resp_word  = acc;

  rotr_var #(.WORD_W(WORD_W), .AMT_W(AMT_W)) u_rotr (
    .x   (opnd),
    .amt (amt),
    .shr (shr),
    .y   (unit_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      func       <= F_BSIG0;
      step       <= 2'd0;
      opnd       <= '0;
      acc        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opnd      <= req_word;
            func      <= func_t'(req_func);
            acc       <= '0;
            step      <= 2'd0;
            state     <= OP0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        OP0: begin
          acc   <= acc ^ unit_out;
          step  <= step + 2'd1;
          state <= OP1;
        end
        OP1: begin
          acc   <= acc ^ unit_out;
          step  <= step + 2'd1;
          state <= OP2;
        end
        OP2: begin
          acc        <= acc ^ unit_out;
          step       <= 2'd0;
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          step       <= 2'd0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sigma_seq.sv
// Self-checking bench for sha256_sigma_seq against a behavioural sigma model.
// Directed cases first, then a randomized request/response stream.
module tb_sha256_sigma_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_func = 2'd0;
  logic [31:0] req_word = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_word;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_sigma_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_word   (req_word),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_word  (resp_word),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] sigma_ref(input logic [1:0] f, input logic [31:0] x);
    case (f)
      2'd0:    return ror(x, 2)  ^ ror(x, 13) ^ ror(x, 22);
      2'd1:    return ror(x, 6)  ^ ror(x, 11) ^ ror(x, 25);
      2'd2:    return ror(x, 7)  ^ ror(x, 18) ^ (x >> 3);
      default: return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] f, input logic [31:0] x, input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_func  = f;
    req_word  = x;
    tick();
    req_valid = 1'b0;
    req_func  = 2'($urandom);
    req_word  = $urandom;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_val"}, resp_word, sigma_ref(f, x));
  endtask

  initial begin
    logic [31:0] held;
    int          cyc;
    int          n_sent;
    int          n_recv;
    bit          fire_req;
    bit          fire_resp;
    logic [31:0] exp_q[$];

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_word", resp_word, 32'd0);

    // Known vectors
    resp_ready = 1'b1;
    do_req(2'd0, 32'h0000_0001, "bsig0_one");
    chk("bsig0_one_k", resp_word, 32'h4008_0400);
    do_req(2'd1, 32'h0000_0001, "bsig1_one");
    chk("bsig1_one_k", resp_word, 32'h0420_0080);
    do_req(2'd2, 32'h0000_0001, "ssig0_one");
    chk("ssig0_one_k", resp_word, 32'h0200_4000);
    do_req(2'd3, 32'h0000_0001, "ssig1_one");
    chk("ssig1_one_k", resp_word, 32'h0000_A000);
    do_req(2'd2, 32'hFFFF_FFFF, "ssig0_ones");
    chk("ssig0_ones_k", resp_word, 32'h1FFF_FFFF);
    do_req(2'd0, 32'hFFFF_FFFF, "bsig0_ones");
    chk("bsig0_ones_k", resp_word, 32'hFFFF_FFFF);
    tick();

    // Back-pressure in DONE
    resp_ready = 1'b0;
    do_req(2'd1, 32'hDEAD_BEEF, "bp");
    held = sigma_ref(2'd1, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        req_valid = 1'b1;
        req_func  = 2'd3;
        req_word  = 32'h1234_5678;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_word", resp_word, held);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    chk("bp_rel_busy", 32'(busy), 32'd0);

    // Reset while in OP1
    req_valid = 1'b1;
    req_func  = 2'd0;
    req_word  = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_word", resp_word, 32'd0);
    do_req(2'd3, 32'hA5A5_0F0F, "after_rst");
    tick();

    // Random stream
    n_sent = 0;
    n_recv = 0;
    cyc    = 0;
    while ((n_sent < 1000 || n_recv < 1000) && cyc < 40000) begin
      @(negedge clk);
      fire_req  = req_valid && req_ready;
      fire_resp = resp_valid && resp_ready;
      if (fire_req) begin
        exp_q.push_back(sigma_ref(req_func, req_word));
        n_sent++;
      end
      if (fire_resp) begin
        chk("stream_have_exp", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) chk("stream_word", resp_word, exp_q.pop_front());
        n_recv++;
      end
      tick();
      cyc++;
      if (fire_req || !req_valid) begin
        if (n_sent < 1000 && $urandom_range(0, 3) != 0) begin
          req_valid = 1'b1;
          req_func  = 2'($urandom);
          req_word  = $urandom;
        end else begin
          req_valid = 1'b0;
          req_func  = 2'($urandom);
          req_word  = $urandom;
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = 1'b0;
    chk("stream_sent", 32'(n_sent), 32'd1000);
    chk("stream_recv", 32'(n_recv), 32'd1000);
    chk("stream_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
